// File: rtl/tc0_pkg.sv
// Shared types and prescaler tap masks for the Timer/Counter0 control sequencer.
package tc0_pkg;

  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_DIV1     = 3'd1,
    CS_DIV8     = 3'd2,
    CS_DIV64    = 3'd3,
    CS_DIV256   = 3'd4,
    CS_DIV1024  = 3'd5,
    CS_T0_FALL  = 3'd6,
    CS_T0_RISE  = 3'd7
  } cs_e;

  typedef enum logic [1:0] {
    WGM_NORMAL   = 2'd0,
    WGM_PC_PWM   = 2'd1,
    WGM_CTC      = 2'd2,
    WGM_FAST_PWM = 2'd3
  } wgm_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam logic [9:0] TAP_DIV8    = 10'd7;
  localparam logic [9:0] TAP_DIV64   = 10'd63;
  localparam logic [9:0] TAP_DIV256  = 10'd255;
  localparam logic [9:0] TAP_DIV1024 = 10'd1023;

endpackage

// File: rtl/tc0_sequencer_if.sv
// Control/status bundle between the TC0 register block/datapath (master) and the sequencer (slave).
interface tc0_sequencer_if;
  logic [2:0] cs;
  logic [1:0] wgm;
  logic       psr;
  logic       t0;
  logic       bottom;
  logic       top;
  logic       toie;
  logic       tov_clr;
  logic       status_reg_interrupt_enable;
  logic       interrupt_executed;
  logic       count;
  logic       clear;
  logic       direction;
  logic       tov;
  logic       interrupt_request;

  modport master (
    output cs, wgm, psr, t0, bottom, top, toie, tov_clr,
           status_reg_interrupt_enable, interrupt_executed,
    input  count, clear, direction, tov, interrupt_request
  );

  modport slave (
    input  cs, wgm, psr, t0, bottom, top, toie, tov_clr,
           status_reg_interrupt_enable, interrupt_executed,
    output count, clear, direction, tov, interrupt_request
  );
endinterface

// File: rtl/tc0_prescaler.sv
// TC0 prescaler: free-running divider with tap decode and, when TC0_EXT_CLK_EN is
// defined, a synchronised t0 edge source for clock selects 6/7.
module tc0_prescaler
  import tc0_pkg::*;
#(
  parameter int PS_W     = 10,
  parameter int SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cs,
  input  logic       psr,
  input  logic       t0,
  output logic       tick,
  output logic       run
);

  cs_e             cs_r;
  logic [PS_W-1:0] ps_r;
  logic            run_s;
  logic            tap_s;
  logic            ext_tick_s;

`ifdef TC0_EXT_CLK_EN
  logic [SYNC_STG-1:0] sync_r;
  logic                prev_r;
  logic                edge_r;

  // Synchronise t0 and register the selected edge so it lands SYNC_STG+1 clocks after the pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
      prev_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], t0};
      prev_r <= sync_r[SYNC_STG-1];
      if (cs_r == CS_T0_RISE) begin
        edge_r <= sync_r[SYNC_STG-1] & ~prev_r;
      end else if (cs_r == CS_T0_FALL) begin
        edge_r <= ~sync_r[SYNC_STG-1] & prev_r;
      end else begin
        edge_r <= 1'b0;
      end
    end
  end

  assign ext_tick_s = edge_r;
`else
  logic [SYNC_STG-1:0] unused_sync_s;
  assign unused_sync_s = {SYNC_STG{t0}};
  assign ext_tick_s    = 1'b0;
`endif

  // Tap decode works from the registered select so reset forces the strobe low.
  always_comb begin
    run_s = 1'b0;
    tap_s = 1'b0;
    case (cs_r)
      CS_STOP: begin
        run_s = 1'b0;
        tap_s = 1'b0;
      end
      CS_DIV1: begin
        run_s = 1'b1;
        tap_s = 1'b1;
      end
      CS_DIV8: begin
        run_s = 1'b1;
        tap_s = ((ps_r[9:0] & TAP_DIV8) == TAP_DIV8);
      end
      CS_DIV64: begin
        run_s = 1'b1;
        tap_s = ((ps_r[9:0] & TAP_DIV64) == TAP_DIV64);
      end
      CS_DIV256: begin
        run_s = 1'b1;
        tap_s = ((ps_r[9:0] & TAP_DIV256) == TAP_DIV256);
      end
      CS_DIV1024: begin
        run_s = 1'b1;
        tap_s = ((ps_r[9:0] & TAP_DIV1024) == TAP_DIV1024);
      end
      CS_T0_FALL, CS_T0_RISE: begin
`ifdef TC0_EXT_CLK_EN
        run_s = 1'b1;
        tap_s = ext_tick_s;
`else
        run_s = 1'b0;
        tap_s = ext_tick_s;
`endif
      end
      default: begin
        run_s = 1'b0;
        tap_s = 1'b0;
      end
    endcase
  end

  // Divider counter restarts on a prescaler reset or any clock-select change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_r <= CS_STOP;
      ps_r <= '0;
    end else begin
      cs_r <= cs_e'(cs);
      if (psr || (cs_e'(cs) != cs_r)) begin
        ps_r <= '0;
      end else if (run_s) begin
        ps_r <= ps_r + PS_W'(1);
      end else begin
        ps_r <= ps_r;
      end
    end
  end

  assign tick = tap_s;
  assign run  = run_s;

endmodule

// File: rtl/tc0_sequencer.sv
// Timer/Counter0 control sequencer: count/clear/direction generation, TOV0 flag and
// interrupt handshake. External t0 clocking is enabled with `define TC0_EXT_CLK_EN.
module tc0_sequencer
  import tc0_pkg::*;
#(
  parameter int PS_W     = 10,
  parameter int SYNC_STG = 2
) (
  input  logic            clk,
  input  logic            rst,
  tc0_sequencer_if.slave  bus
);

  logic tick_s;
  logic run_s;
  logic clear_s;
  logic ovf_s;
  wgm_e wgm_s;
  dir_e dir_r;
  logic tov_r;

  tc0_prescaler #(
    .PS_W     (PS_W),
    .SYNC_STG (SYNC_STG)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cs   (bus.cs),
    .psr  (bus.psr),
    .t0   (bus.t0),
    .tick (tick_s),
    .run  (run_s)
  );

  assign wgm_s = wgm_e'(bus.wgm);

  // Clear and overflow decode; in CTC top is the compare match, so it clears but never overflows.
  always_comb begin
    clear_s = 1'b0;
    ovf_s   = 1'b0;
    case (wgm_s)
      WGM_NORMAL: begin
        clear_s = 1'b0;
        ovf_s   = tick_s & bus.top;
      end
      WGM_PC_PWM: begin
        clear_s = 1'b0;
        ovf_s   = tick_s & bus.bottom & (dir_r == DIR_DOWN);
      end
      WGM_CTC: begin
        clear_s = tick_s & bus.top;
        ovf_s   = 1'b0;
      end
      WGM_FAST_PWM: begin
        clear_s = tick_s & bus.top;
        ovf_s   = tick_s & bus.top;
      end
      default: begin
        clear_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Direction FSM and overflow flag; a new overflow beats a coincident clear or acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_r <= DIR_UP;
      tov_r <= 1'b0;
    end else begin
      if (!run_s) begin
        dir_r <= dir_r;
      end else if (wgm_s != WGM_PC_PWM) begin
        dir_r <= DIR_UP;
      end else begin
        case (dir_r)
          DIR_UP:   dir_r <= (tick_s && bus.top)    ? DIR_DOWN : DIR_UP;
          DIR_DOWN: dir_r <= (tick_s && bus.bottom) ? DIR_UP   : DIR_DOWN;
          default:  dir_r <= DIR_UP;
        endcase
      end

      if (ovf_s) begin
        tov_r <= 1'b1;
      end else if (bus.interrupt_executed || bus.tov_clr) begin
        tov_r <= 1'b0;
      end else begin
        tov_r <= tov_r;
      end
    end
  end

  assign bus.count             = tick_s;
  assign bus.clear             = clear_s;
  assign bus.direction         = dir_r;
  assign bus.tov               = tov_r;
  assign bus.interrupt_request = tov_r & bus.toie & bus.status_reg_interrupt_enable;

endmodule

// File: tb/tb_tc0_sequencer.sv
// Directed bench for tc0_sequencer: reset, prescaler taps, CTC, phase-correct, IRQ and t0 edges.
module tb_tc0_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_pulses;
  int   first_k;
  int   last_k;
  logic exp_bit;

  tc0_sequencer_if bus_if ();

  tc0_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus_if.cs = 3'd0;
    bus_if.wgm = 2'd0;
    bus_if.psr = 1'b0;
    bus_if.t0 = 1'b0;
    bus_if.bottom = 1'b0;
    bus_if.top = 1'b0;
    bus_if.toie = 1'b0;
    bus_if.tov_clr = 1'b0;
    bus_if.status_reg_interrupt_enable = 1'b0;
    bus_if.interrupt_executed = 1'b0;

    // Reset state
    repeat (2) cycle();
    #3;
    chk("rst_count", 32'(bus_if.count), 32'd0);
    chk("rst_clear", 32'(bus_if.clear), 32'd0);
    chk("rst_dir", 32'(bus_if.direction), 32'd1);
    chk("rst_tov", 32'(bus_if.tov), 32'd0);
    chk("rst_irq", 32'(bus_if.interrupt_request), 32'd0);

    // Test 1: run at /1, set tov in normal mode, then reset mid-count
    cycle(); rst = 1'b1; bus_if.cs = 3'd1;
    cycle(); #3;
    chk("t1_count_run", 32'(bus_if.count), 32'd1);
    bus_if.top = 1'b1; #1;
    chk("t1_normal_noclear", 32'(bus_if.clear), 32'd0);
    cycle(); bus_if.top = 1'b0; #3;
    chk("t1_tov_set", 32'(bus_if.tov), 32'd1);
    chk("t1_irq_masked", 32'(bus_if.interrupt_request), 32'd0);
    rst = 1'b0; #1;
    chk("t1_rst_count", 32'(bus_if.count), 32'd0);
    chk("t1_rst_clear", 32'(bus_if.clear), 32'd0);
    chk("t1_rst_dir", 32'(bus_if.direction), 32'd1);
    chk("t1_rst_tov", 32'(bus_if.tov), 32'd0);
    cycle(); rst = 1'b1;
    cycle();

    // Test 2: /64 after psr, then switch to /1024
    bus_if.cs = 3'd3; bus_if.psr = 1'b1;
    cycle(); bus_if.psr = 1'b0;
    n_pulses = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 128; k++) begin
      #3;
      if (bus_if.count === 1'b1) begin
        n_pulses++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      cycle();
    end
    chk("t2_div64_first", 32'(first_k), 32'd63);
    chk("t2_div64_last", 32'(last_k), 32'd127);
    chk("t2_div64_num", 32'(n_pulses), 32'd2);
    bus_if.cs = 3'd5;
    n_pulses = 0; first_k = -1;
    for (int k = 0; k < 1100; k++) begin
      cycle(); #3;
      if (bus_if.count === 1'b1) begin
        n_pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    chk("t2_div1024_first", 32'(first_k), 32'd1023);
    chk("t2_div1024_num", 32'(n_pulses), 32'd1);

    // Test 3: CTC, top every 10th cycle
    bus_if.cs = 3'd1; bus_if.wgm = 2'd2; bus_if.top = 1'b0; bus_if.bottom = 1'b0;
    cycle();
    for (int k = 0; k < 30; k++) begin
      bus_if.top = ((k % 10) == 9);
      #3;
      chk("t3_ctc_clear", 32'(bus_if.clear), 32'((k % 10) == 9));
      chk("t3_ctc_count", 32'(bus_if.count), 32'd1);
      cycle();
    end
    bus_if.top = 1'b0; #3;
    chk("t3_ctc_tov", 32'(bus_if.tov), 32'd0);

    // Test 4: phase-correct up/down and overflow at bottom
    cycle(); bus_if.wgm = 2'd1; bus_if.bottom = 1'b1; #3;
    chk("t4_dir_start", 32'(bus_if.direction), 32'd1);
    cycle(); bus_if.bottom = 1'b0; #3;
    chk("t4_no_ovf_up_bottom", 32'(bus_if.tov), 32'd0);
    cycle(); bus_if.top = 1'b1; #3;
    chk("t4_pc_noclear", 32'(bus_if.clear), 32'd0);
    chk("t4_dir_at_top", 32'(bus_if.direction), 32'd1);
    cycle(); bus_if.top = 1'b0; #3;
    chk("t4_dir_down", 32'(bus_if.direction), 32'd0);
    chk("t4_tov_at_top", 32'(bus_if.tov), 32'd0);
    cycle(); bus_if.bottom = 1'b1; #3;
    chk("t4_dir_at_bottom", 32'(bus_if.direction), 32'd0);
    cycle(); bus_if.bottom = 1'b0; #3;
    chk("t4_dir_up", 32'(bus_if.direction), 32'd1);
    chk("t4_tov_bottom", 32'(bus_if.tov), 32'd1);
    cycle(); bus_if.tov_clr = 1'b1; #3;
    chk("t4_tov_hold", 32'(bus_if.tov), 32'd1);
    cycle(); bus_if.tov_clr = 1'b0; bus_if.bottom = 1'b1; #3;
    chk("t4_tov_cleared", 32'(bus_if.tov), 32'd0);
    cycle(); bus_if.bottom = 1'b0; #3;
    chk("t4_tov_once", 32'(bus_if.tov), 32'd0);
    chk("t4_dir_still_up", 32'(bus_if.direction), 32'd1);

    // Test 5: fast PWM overflow and interrupt handshake
    cycle(); bus_if.wgm = 2'd3; bus_if.toie = 1'b1;
    bus_if.status_reg_interrupt_enable = 1'b1; bus_if.top = 1'b1; #3;
    chk("t5_fpwm_clear", 32'(bus_if.clear), 32'd1);
    chk("t5_irq_before", 32'(bus_if.interrupt_request), 32'd0);
    cycle(); bus_if.top = 1'b0; #3;
    chk("t5_tov_set", 32'(bus_if.tov), 32'd1);
    chk("t5_irq_set", 32'(bus_if.interrupt_request), 32'd1);
    bus_if.status_reg_interrupt_enable = 1'b0; #1;
    chk("t5_irq_gie_off", 32'(bus_if.interrupt_request), 32'd0);
    bus_if.status_reg_interrupt_enable = 1'b1;
    cycle(); bus_if.interrupt_executed = 1'b1; #3;
    chk("t5_irq_during_ack", 32'(bus_if.interrupt_request), 32'd1);
    cycle(); bus_if.interrupt_executed = 1'b0; #3;
    chk("t5_irq_dropped", 32'(bus_if.interrupt_request), 32'd0);
    chk("t5_tov_acked", 32'(bus_if.tov), 32'd0);
    cycle(); bus_if.top = 1'b1; #3;
    cycle(); bus_if.interrupt_executed = 1'b1; #3;
    chk("t5_tov_reset", 32'(bus_if.tov), 32'd1);
    cycle(); bus_if.interrupt_executed = 1'b0; bus_if.top = 1'b0; #3;
    chk("t5_set_wins", 32'(bus_if.tov), 32'd1);
    chk("t5_irq_set_wins", 32'(bus_if.interrupt_request), 32'd1);
    cycle(); bus_if.tov_clr = 1'b1; #3;
    cycle(); bus_if.tov_clr = 1'b0; #3;
    chk("t5_tov_clr", 32'(bus_if.tov), 32'd0);

    // Test 6: external t0 rising edges with cs=7
    cycle(); bus_if.wgm = 2'd0; bus_if.cs = 3'd7; bus_if.toie = 1'b0; #3;
    cycle(); #3;
    chk("t6_idle", 32'(bus_if.count), 32'd0);
    n_pulses = 0;
    for (int c = 0; c < 48; c++) begin
      bus_if.t0 = (c < 40) && ((c % 8) < 4);
      cycle(); #3;
`ifdef TC0_EXT_CLK_EN
      exp_bit = (c < 40) && ((c % 8) == 2);
`else
      exp_bit = 1'b0;
`endif
      chk("t6_ext_count", 32'(bus_if.count), 32'(exp_bit));
      if (bus_if.count === 1'b1) n_pulses++;
    end
`ifdef TC0_EXT_CLK_EN
    chk("t6_ext_num", 32'(n_pulses), 32'd5);
`else
    chk("t6_ext_num", 32'(n_pulses), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
